// File: rtl/fifo_no_space_ctrl_if.sv
// fifo_no_space_ctrl_if
//   Bundles the push/pop handshake, occupancy flags and the no-space error
//   outputs of fifo_no_space_ctrl.
//   master : producer/consumer side (drives push, push_data, pop, cnt_clr)
//   slave  : the buffer itself (drives pop_data, pop_valid, full, empty,
//            level, no_space_err, no_space_ctr_incr, no_space_cnt)
interface fifo_no_space_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic              push;
  logic [DATA_W-1:0] push_data;
  logic              pop;
  logic [DATA_W-1:0] pop_data;
  logic              pop_valid;
  logic              full;
  logic              empty;
  logic [LW-1:0]     level;
  logic              no_space_err;
  logic              no_space_ctr_incr;
  logic [CNT_W-1:0]  no_space_cnt;
  logic              cnt_clr;

  modport master (
    output push, push_data, pop, cnt_clr,
    input  pop_data, pop_valid, full, empty, level,
           no_space_err, no_space_ctr_incr, no_space_cnt
  );

  modport slave (
    input  push, push_data, pop, cnt_clr,
    output pop_data, pop_valid, full, empty, level,
           no_space_err, no_space_ctr_incr, no_space_cnt
  );
endinterface

// File: rtl/fifo_no_space_ctrl.sv
// fifo_no_space_ctrl
//   Circular write buffer with admission control. Pushes arriving while the
//   buffer is full (and not relieved by a same-cycle pop) are dropped and
//   flagged on no_space_err; each run of consecutive drops gives one
//   no_space_ctr_incr pulse, counted by a saturating episode counter.
//   Ports:
//     clk  - clock, all state on posedge
//     rst  - asynchronous active-high reset
//     bus  - fifo_no_space_ctrl_if.slave (push/pop handshake, flags, errors)
//   DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module fifo_no_space_ctrl #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_no_space_ctrl_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [LW-1:0]     level_reg;
  logic [DATA_W-1:0] pop_data_reg;
  logic              pop_valid_reg;
  logic              err_reg;
  logic              err_d_reg;
  logic              incr_reg;
  logic [CNT_W-1:0]  cnt_reg;

  logic full_w;
  logic empty_w;
  logic pop_acc;
  logic push_acc;
  logic push_rej;

  assign full_w  = (level_reg == LW'(DEPTH));
  assign empty_w = (level_reg == '0);

  // A pop on empty is ignored even if a push arrives in the same cycle;
  // a pop frees a slot so a push while full is still admitted.
  assign pop_acc  = bus.pop && !empty_w;
  assign push_acc = bus.push && (!full_w || pop_acc);
  assign push_rej = bus.push && !push_acc;

  // Storage has no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wr_ptr_reg] <= bus.push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      pop_data_reg  <= '0;
      pop_valid_reg <= 1'b0;
    end else begin
      pop_valid_reg <= pop_acc;
      if (pop_acc) begin
        pop_data_reg <= mem[rd_ptr_reg];
        rd_ptr_reg   <= rd_ptr_reg + 1'b1;
      end
      if (push_acc) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      level_reg <= level_reg + LW'(push_acc) - LW'(pop_acc);
    end
  end

  // Error chain: err marks each dropped push, incr fires on the first cycle
  // of a run of err (rising edge), the counter consumes incr one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_reg   <= 1'b0;
      err_d_reg <= 1'b0;
      incr_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      err_reg   <= push_rej;
      err_d_reg <= err_reg;
      incr_reg  <= err_reg && !err_d_reg;
      // Clear wins over a coincident pulse; that pulse is not counted.
      if (bus.cnt_clr) begin
        cnt_reg <= '0;
      end else if (incr_reg && (cnt_reg != {CNT_W{1'b1}})) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign bus.pop_data          = pop_data_reg;
  assign bus.pop_valid         = pop_valid_reg;
  assign bus.full              = full_w;
  assign bus.empty             = empty_w;
  assign bus.level             = level_reg;
  assign bus.no_space_err      = err_reg;
  assign bus.no_space_ctr_incr = incr_reg;
  assign bus.no_space_cnt      = cnt_reg;
endmodule
